// File: rtl/cronos_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cronos_pkg : shared state encoding and default timing for cronos_ctrl
// Revision   : 1.0
// ----------------------------------------------------------------------------
package cronos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } ctrl_state_t;

  // 100 Hz count tick from a 100 MHz oscillator
  localparam int unsigned CRONOS_CLK_DIV    = 1_000_000;
  localparam int unsigned CRONOS_DEB_CYCLES = 16;

endpackage
`default_nettype wire

// File: rtl/cronos_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cronos_debounce : 2-FF synchronizer, stable-sample filter and press pulse
// Revision        : 1.0
// ----------------------------------------------------------------------------
module cronos_debounce
  import cronos_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = CRONOS_DEB_CYCLES
) (
  input  logic osc_clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge osc_clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      // a sample agreeing with the current level breaks the run
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = level_q & ~level_prev_q;

endmodule
`default_nettype wire

// File: rtl/cronos_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cronos_ctrl : stopwatch run-control FSM, count prescaler and button cleanup
// Revision    : 1.0
// ----------------------------------------------------------------------------
module cronos_ctrl
  import cronos_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CRONOS_CLK_DIV,
  parameter int unsigned DEB_CYCLES = CRONOS_DEB_CYCLES
) (
  input  logic       osc_clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lc,
  output logic       cnt_tick,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state_o
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic ss_press;
  logic lc_press;

  cronos_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .osc_clk (osc_clk),
    .reset   (reset),
    .btn_raw (btn_ss),
    .press   (ss_press)
  );

  cronos_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lc (
    .osc_clk (osc_clk),
    .reset   (reset),
    .btn_raw (btn_lc),
    .press   (lc_press)
  );

  ctrl_state_t   state_q, state_d;
  logic          clr_q, clr_d;
  logic [PW-1:0] presc_q, presc_d;

  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      presc_q <= presc_d;
    end
  end

  // start/stop has priority: a coincident lap/clear press is dropped
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_press)      state_d = RUN;
        else if (lc_press) clr_d   = 1'b1;
      end
      RUN: begin
        if (ss_press)      state_d = STOP;
        else if (lc_press) state_d = LAP;
      end
      LAP: begin
        if (ss_press)      state_d = STOP;
        else if (lc_press) state_d = RUN;
      end
      STOP: begin
        if (ss_press) begin
          state_d = RUN;
        end else if (lc_press) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign running   = (state_q == RUN) || (state_q == LAP);
  assign disp_hold = (state_q == LAP);
  assign state_o   = state_q;
  assign cnt_clr   = clr_q;
  assign cnt_tick  = running && (presc_q == PRESC_LAST);

  // STOP freezes the fraction so a resume continues mid-period
  always_comb begin
    presc_d = presc_q;
    if (state_d == IDLE) begin
      presc_d = '0;
    end else if (running) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cronos_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cronos_ctrl : scoreboard bench for cronos_ctrl with a behavioural model
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_cronos_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;

  logic       osc_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       btn_ss  = 1'b0;
  logic       btn_lc  = 1'b0;
  logic       cnt_tick, cnt_clr, disp_hold, running;
  logic [1:0] state_o;

  cronos_ctrl #(.CLK_DIV(CLK_DIV), .DEB_CYCLES(DEB)) dut (
    .osc_clk   (osc_clk),
    .reset     (reset),
    .btn_ss    (btn_ss),
    .btn_lc    (btn_lc),
    .cnt_tick  (cnt_tick),
    .cnt_clr   (cnt_clr),
    .disp_hold (disp_hold),
    .running   (running),
    .state_o   (state_o)
  );

  always #5 osc_clk = ~osc_clk;

  int errors = 0;
  int checks = 0;
  int n_tick = 0;
  int n_clr  = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: button seen through a two-edge delay, a press is a
  // run of DEB delayed samples at 1 while the filtered level is 0, and the
  // tick phase is the running-cycle count modulo CLK_DIV.
  int  m_state = 0;
  int  m_presc = 0;
  bit  m_clr   = 0;
  bit  m_d1[2], m_d2[2], m_lvl[2], m_ev[2];
  int  m_run[2];

  always @(posedge osc_clk) begin
    int         ns;
    bit         clr, run_old, run_new;
    bit         raw[2];
    logic [5:0] e;
    raw[0] = btn_ss;
    raw[1] = btn_lc;
    if (reset) begin
      m_state = 0; m_presc = 0; m_clr = 0;
      for (int b = 0; b < 2; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_ev[b] = 0; m_run[b] = 0;
      end
    end else begin
      run_old = (m_state == 1) || (m_state == 2);
      ns  = m_state;
      clr = 0;
      if (m_ev[0]) begin
        ns = (m_state == 0 || m_state == 3) ? 1 : 3;
      end else if (m_ev[1]) begin
        case (m_state)
          0: clr = 1;
          1: ns = 2;
          2: ns = 1;
          default: begin ns = 0; clr = 1; end
        endcase
      end
      if (ns == 0)      m_presc = 0;
      else if (run_old) m_presc = (m_presc + 1) % CLK_DIV;
      m_state = ns;
      m_clr   = clr;
      for (int b = 0; b < 2; b++) begin
        m_ev[b] = 0;
        if (m_d2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_lvl[b] = m_d2[b];
            m_run[b] = 0;
            m_ev[b]  = m_lvl[b];
          end
        end else begin
          m_run[b] = 0;
        end
        m_d2[b] = m_d1[b];
        m_d1[b] = raw[b];
      end
    end
    run_new = (m_state == 1) || (m_state == 2);
    e = {m_state[1:0], run_new && (m_presc == CLK_DIV - 1), m_clr, m_state == 2, run_new};
    exp_q.push_back(e);
  end

  always @(negedge osc_clk) begin
    logic [5:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state_o, cnt_tick, cnt_clr, disp_hold, running};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard {state,tick,clr,hold,run}: got %b, required %b at %0t", a, e, $time);
      end
      if (cnt_tick === 1'b1) n_tick++;
      if (cnt_clr  === 1'b1) n_clr++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge osc_clk);
    #2;
  endtask

  task automatic press(input logic ss, input logic lc);
    btn_ss = ss;
    btn_lc = lc;
    idle(10);
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    idle(10);
  endtask

  initial begin
    int s;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(50);
    check("idle state", state_o, 0);
    check("idle ticks", n_tick, 0);
    check("idle clears", n_clr, 0);
    check("idle hold", disp_hold, 0);

    press(1, 0);
    check("start -> RUN", state_o, 1);
    s = n_tick; idle(40);
    check("ticks in 40 run cycles", n_tick - s, 10);

    press(0, 1);
    check("lap state", state_o, 2);
    check("lap hold", disp_hold, 1);
    s = n_tick; idle(8);
    check("ticks during lap", n_tick - s, 2);
    press(0, 1);
    check("lap release state", state_o, 1);
    check("lap release hold", disp_hold, 0);

    press(1, 0);
    check("stop state", state_o, 3);
    s = n_tick; idle(20);
    check("ticks in stop", n_tick - s, 0);
    press(1, 0);
    check("resume state", state_o, 1);
    press(1, 0);
    check("stop again", state_o, 3);

    s = n_clr; press(0, 1);
    check("clear from stop state", state_o, 0);
    check("clear from stop pulses", n_clr - s, 1);
    s = n_clr; press(0, 1);
    check("clear in idle state", state_o, 0);
    check("clear in idle pulses", n_clr - s, 1);

    repeat (5) begin
      btn_ss = 1'b1; idle(2);
      btn_ss = 1'b0; idle(2);
    end
    idle(10);
    check("bounce ignored", state_o, 0);

    press(1, 0);
    check("run before dual press", state_o, 1);
    press(1, 1);
    check("dual press -> STOP", state_o, 3);
    check("dual press hold", disp_hold, 0);

    press(1, 0);
    press(0, 1);
    check("lap before reset", state_o, 2);
    reset = 1'b1;
    idle(1);
    check("reset state", state_o, 0);
    check("reset hold", disp_hold, 0);
    check("reset running", running, 0);
    check("reset tick", cnt_tick, 0);
    check("reset clr", cnt_clr, 0);
    reset = 1'b0;
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 6) == 0) btn_ss = ~btn_ss;
      if ($urandom_range(0, 6) == 0) btn_lc = ~btn_lc;
      reset = ($urandom_range(0, 499) == 0);
      idle(1);
    end
    reset  = 1'b0;
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cronos_ctrl.md
Name: cronos_ctrl

Overview:
- Run-control sequencer for the stopwatch datapath inside Top_Cronos.
- Turns two raw push-buttons into clean press events and runs a START/STOP/LAP/CLEAR state machine.
- Generates the count-enable tick from osc_clk through a prescaler.
- Drives the BCD counter (tick, clear) and the display mux (hold/freeze for lap).

Parameters:
- CLK_DIV, 1_000_000: osc_clk cycles per count tick (100 Hz at 100 MHz); minimum 2.
- DEB_CYCLES, 16: consecutive stable samples required before a debounced level changes; minimum 1.

Ports:
- osc_clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- btn_ss  in  1  raw start/stop button, asynchronous, active-high
- btn_lc  in  1  raw lap/clear button, asynchronous, active-high
- cnt_tick  out  1  one-cycle pulse; counter increments by one
- cnt_clr  out  1  one-cycle pulse; counter clears to 00.00
- disp_hold  out  1  level; display latches and shows frozen lap value
- running  out  1  level; high in RUN and LAP
- state_o  out  2  current state encoding (debug/LED)

Behaviour:
- One clock; reset is synchronous and active-high. Clock port osc_clk, reset port reset.
- Reset values:
  - state = IDLE; cnt_tick, cnt_clr, disp_hold and running = 0; state_o = 2'd0.
  - Prescaler = 0; debouncer sync flops, counters and levels = 0.
- Debounce, per button:
  - 2-FF synchronizer feeds a stable-counter.
  - Debounced level takes the synced value after DEB_CYCLES consecutive equal samples that differ from the current level.
  - Any mismatch restarts the count.
  - Press event = one-cycle pulse on a 0->1 transition of the debounced level. Release produces no event.
  - Raw input rising and held: event pulse is high in cycle 2+DEB_CYCLES after the first sampling edge; state updates at the next edge.
- States (state_o encoding) and transitions:
  - IDLE (0):
    - ss event -> RUN.
    - lc event -> stay IDLE and pulse cnt_clr.
  - RUN (1):
    - ss -> STOP.
    - lc -> LAP.
  - LAP (2):
    - ss -> STOP and release hold.
    - lc -> RUN and release hold.
  - STOP (3):
    - ss -> RUN, resuming count.
    - lc -> IDLE; pulse cnt_clr and clear the prescaler.
- Simultaneous ss and lc events in one cycle: ss wins, lc is discarded.
- Output decoding:
  - disp_hold = 1 exactly while in LAP.
  - running = 1 in RUN and LAP.
  - cnt_clr is a registered pulse, high the cycle after the transition edge.
- Prescaler:
  - Counts 0..CLK_DIV-1 only while running.
  - Holds its value in STOP, so the fraction is preserved on resume.
  - Forced to 0 on entry to IDLE.
  - cnt_tick is high for the single cycle in which prescaler == CLK_DIV-1 while running; the prescaler wraps to 0 on the next edge.
  - First tick occurs CLK_DIV cycles after entering RUN from IDLE.
- LAP: counter keeps ticking (running=1); only the display is frozen.
- No tick may coincide with cnt_clr: clear is only issued from IDLE or STOP, where running=0.
- Reset mid-operation: all state returns to IDLE and all outputs to their reset values on the next edge. No cnt_clr pulse is generated by reset; the counter has its own reset.
- Widths:
  - Prescaler width = $clog2(CLK_DIV).
  - Debounce counter width = $clog2(DEB_CYCLES+1).
  - Comparisons are unsigned.

Decomposition:
- Package cronos_pkg:
  - typedef enum logic [1:0] ctrl_state_t {IDLE=0, RUN=1, LAP=2, STOP=3}.
  - Default CLK_DIV and DEB_CYCLES constants.
- Sub-module cronos_debounce (params DEB_CYCLES; ports osc_clk, reset, btn_raw, press): instantiated twice.
- Prescaler and FSM stay in cronos_ctrl.

Test Plan (CLK_DIV=4, DEB_CYCLES=3):
- Reset held 2 cycles, then buttons idle 50 cycles -> state_o=0; cnt_tick, cnt_clr and disp_hold stay 0.
- btn_ss high 10 cycles from IDLE -> state_o=1 one cycle after press pulse; cnt_tick pulses every 4 cycles, first at 4 cycles after entry; 10 ticks counted over 40 cycles.
- RUN, btn_lc press -> disp_hold=1, state_o=2, ticks continue. Second btn_lc press -> disp_hold=0, state_o=1.
- RUN, press ss after prescaler=2 -> STOP with no ticks. Press ss again -> first tick 2 cycles after re-entering RUN (fraction preserved).
- STOP, press lc -> state_o=0, cnt_clr high exactly 1 cycle, prescaler 0. In IDLE, press lc -> another single cnt_clr pulse, state stays 0.
- Bounce check: btn_ss toggled 1/0 every 2 cycles for 20 cycles -> no press event. Both buttons pressed together from RUN -> STOP, disp_hold=0. Assert reset while in LAP -> all outputs 0 and state_o=0 next edge.
